// File: rtl/cpu_clk_monitor.sv
// cpu_clk_monitor: measures clk_in half-period in sysclk cycles, locks when in tolerance, flags short/long/stuck clocks.
// Optional min/max statistics are built when CLK_MON_STATS_EN is defined.
module cpu_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 3,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             en,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [15:0]      edge_cnt,
  output logic [CNT_W-1:0] min_half,
  output logic [CNT_W-1:0] max_half
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  typedef enum logic [2:0] {IDLE, ACQUIRE, TRACK, LOCKED, FAULT} state_t;
  state_t state;
  logic s1, s2, s3, edge_q, publish, timeout, too_short, too_long;
  logic [CNT_W-1:0] run_cnt, meas;
  logic [CNT_W:0] run_nxt;
  logic [GW-1:0] good_cnt;
  assign run_nxt   = {1'b0, run_cnt} + 1'b1;
  assign meas      = &run_cnt ? run_cnt : run_nxt[CNT_W-1:0];
  assign timeout   = int'(run_nxt) >= TIMEOUT;
  assign too_short = int'(meas) < EXP_HALF - TOL;
  assign too_long  = int'(meas) > EXP_HALF + TOL;
  assign publish   = edge_q && en && (state == TRACK || state == LOCKED || state == FAULT);
  // edge_q adds one stage so a measurement appears three cycles after clk_in is first sampled
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      edge_q      <= 1'b0;
      run_cnt     <= '0;
      state       <= IDLE;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      edge_cnt    <= '0;
      good_cnt    <= '0;
    end else begin
      s1         <= clk_in;
      s2         <= s1;
      s3         <= s2;
      edge_q     <= s2 ^ s3;
      meas_valid <= publish;
      run_cnt    <= (edge_q || state == IDLE) ? '0 : meas;
      if (publish) half_period <= meas;
      if (edge_q && en && state != IDLE) edge_cnt <= edge_cnt + 16'd1;
      if (!en) begin
        state      <= IDLE;
        locked     <= 1'b0;
        fault      <= 1'b0;
        fault_code <= 2'b00;
        good_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ACQUIRE;
            edge_cnt <= '0;
          end
          ACQUIRE: begin
            if (edge_q) state <= TRACK;
            else if (timeout) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b11;
            end
          end
          TRACK, LOCKED: begin
            if (edge_q) begin
              if (too_short || too_long) begin
                state      <= FAULT;
                fault      <= 1'b1;
                locked     <= 1'b0;
                fault_code <= too_short ? 2'b01 : 2'b10;
              end else if (state == TRACK) begin
                good_cnt <= good_cnt + 1'b1;
                if (good_cnt == GW'(LOCK_CNT - 1)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end else if (timeout) begin
              state      <= FAULT;
              fault      <= 1'b1;
              locked     <= 1'b0;
              fault_code <= 2'b11;
            end
          end
          FAULT: state <= FAULT;
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef CLK_MON_STATS_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      min_half <= '1;
      max_half <= '0;
    end else if (en && state == IDLE) begin
      min_half <= '1;
      max_half <= '0;
    end else if (publish) begin
      min_half <= meas < min_half ? meas : min_half;
      max_half <= meas > max_half ? meas : max_half;
    end
  end
`else
  assign min_half = '0;
  assign max_half = '0;
`endif
endmodule

// File: tb/tb_cpu_clk_monitor.sv
// tb_cpu_clk_monitor: directed checks of measurement, lock, fault codes, timeout, reset and stats.
module tb_cpu_clk_monitor;
  logic sysclk = 1'b0, reset = 1'b1, clk_in = 1'b0, en = 1'b0;
  logic [7:0] half_period, min_half, max_half;
  logic meas_valid, locked, fault;
  logic [1:0] fault_code;
  logic [15:0] edge_cnt;
  int checks = 0, errors = 0, per = 0, ph = 0, mv_cnt = 0;
  bit alt = 1'b0;
`ifdef CLK_MON_STATS_EN
  localparam logic [31:0] MIN_RST = 32'hFF, MIN_EXP = 32'd2, MAX_EXP = 32'd4;
`else
  localparam logic [31:0] MIN_RST = 32'd0, MIN_EXP = 32'd0, MAX_EXP = 32'd0;
`endif
  cpu_clk_monitor dut (
    .sysclk(sysclk), .reset(reset), .clk_in(clk_in), .en(en),
    .half_period(half_period), .meas_valid(meas_valid), .locked(locked),
    .fault(fault), .fault_code(fault_code), .edge_cnt(edge_cnt),
    .min_half(min_half), .max_half(max_half)
  );
  always #5 sysclk = ~sysclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one sysclk cycle; clk_in toggles every per cycles (alternating 2/4 when alt)
  task automatic step();
    @(posedge sysclk);
    #1;
    if (meas_valid) mv_cnt++;
    if (per != 0) begin
      ph++;
      if (ph >= per) begin
        ph = 0;
        clk_in = ~clk_in;
        if (alt) per = (per == 2) ? 4 : 2;
      end
    end
  endtask
  task automatic wait_mv(input int n, input int budget);
    int k = 0;
    while (mv_cnt < n && k < budget) begin
      step();
      k++;
    end
    check("mv_reached", 32'(mv_cnt >= n), 32'd1);
  endtask
  task automatic wait_fault(input int budget);
    int k = 0;
    while (!fault && k < budget) begin
      step();
      k++;
    end
    check("fault_reached", 32'(fault), 32'd1);
  endtask
  task automatic idle(input int n);
    en = 1'b0;
    per = 0;
    alt = 1'b0;
    clk_in = 1'b0;
    repeat (n) step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    check("rst_half", 32'(half_period), 32'd0);
    check("rst_mv", 32'(meas_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    check("rst_edges", 32'(edge_cnt), 32'd0);
    check("rst_min", 32'(min_half), MIN_RST);
    check("rst_max", 32'(max_half), 32'd0);
    reset = 1'b0;
    repeat (2) step();
    en = 1'b1; per = 3; ph = 0; mv_cnt = 0;
    wait_mv(3, 60);
    check("prelock_locked", 32'(locked), 32'd0);
    wait_mv(4, 20);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_half", 32'(half_period), 32'd3);
    check("lock_fault", 32'(fault), 32'd0);
    check("lock_edges", 32'(edge_cnt), 32'd5);
    per = 6;
    wait_fault(60);
    check("long_code", 32'(fault_code), 32'd2);
    check("long_locked", 32'(locked), 32'd0);
    check("long_half", 32'(half_period), 32'd6);
    per = 3; mv_cnt = 0;
    wait_mv(2, 30);
    check("sticky_fault", 32'(fault), 32'd1);
    check("sticky_code", 32'(fault_code), 32'd2);
    check("sticky_half", 32'(half_period), 32'd3);
    en = 1'b0;
    step();
    check("dis_fault", 32'(fault), 32'd0);
    check("dis_code", 32'(fault_code), 32'd0);
    check("dis_locked", 32'(locked), 32'd0);
    idle(6);
    en = 1'b1; per = 1; ph = 0;
    wait_fault(40);
    check("short_code", 32'(fault_code), 32'd1);
    check("short_half", 32'(half_period), 32'd1);
    idle(6);
    en = 1'b1;
    repeat (16) step();
    check("to_early", 32'(fault), 32'd0);
    step();
    check("to_fault", 32'(fault), 32'd1);
    check("to_code", 32'(fault_code), 32'd3);
    idle(6);
    en = 1'b1; per = 2; alt = 1'b1; ph = 0; mv_cnt = 0;
    wait_mv(6, 80);
    check("stats_min", 32'(min_half), MIN_EXP);
    check("stats_max", 32'(max_half), MAX_EXP);
    check("stats_fault", 32'(fault), 32'd0);
    idle(6);
    en = 1'b1; per = 3; ph = 0; mv_cnt = 0;
    wait_mv(5, 80);
    check("relock", 32'(locked), 32'd1);
    reset = 1'b1;
    #1;
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_half", 32'(half_period), 32'd0);
    check("mrst_edges", 32'(edge_cnt), 32'd0);
    check("mrst_mv", 32'(meas_valid), 32'd0);
    check("mrst_fault", 32'(fault), 32'd0);
    check("mrst_code", 32'(fault_code), 32'd0);
    check("mrst_min", 32'(min_half), MIN_RST);
    check("mrst_max", 32'(max_half), 32'd0);
    idle(2);
    reset = 1'b0;
    repeat (2) step();
    check("post_locked", 32'(locked), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
